imm_gen_stage: RTL

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: upstream instruction side and downstream
// immediate side. The stage itself connects through the slave modport.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_imm_src;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_imm_src, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_imm_src, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate generation stage behind a 2-entry main/skid buffer with registered in_ready.
// Optional macro IMM_GEN_ZIMM_EN makes select 5 (CSR zimm) a legal format.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           err_clr,
  output logic           err_sticky,
  imm_gen_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic             illegal;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Returns {illegal, immediate}; illegal selects produce a zero immediate.
  function automatic logic [XLEN:0] calc_imm(input logic [2:0] src, input logic [31:7] ins);
    logic [31:0]     v;
    logic [XLEN-1:0] r;
    logic            ill;
    v   = 32'd0;
    ill = 1'b0;
    case (src)
      3'd0:    v = {{20{ins[31]}}, ins[31:20]};
      3'd1:    v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2:    v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3:    v = {ins[31:12], 12'd0};
      3'd4:    v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      3'd5:    v = {27'd0, ins[19:15]};
`endif
      default: ill = 1'b1;
    endcase
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return {ill, r};
  endfunction

  state_e         state_q, state_d;
  entry_t         main_q, main_d;
  entry_t         skid_q, skid_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;
  logic [XLEN:0]  calc_s;
  entry_t         new_s;
  logic           accept_s;
  logic           deliver_s;
  logic           unused_instr_s;

  assign calc_s         = calc_imm(bus.in_imm_src, bus.in_instr[31:7]);
  assign new_s          = {calc_s, bus.in_tag};
  assign unused_instr_s = ^bus.in_instr[6:0];

  // Next-state decode: flush wins over everything, then deliver/accept per occupancy.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    err_d     = err_q;
    accept_s  = bus.in_valid && in_ready_q && !flush;
    deliver_s = out_valid_q && bus.out_ready;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_d  = new_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && deliver_s) begin
            main_d  = new_s;
            state_d = ST_ONE;
          end else if (accept_s) begin
            skid_d  = new_s;
            state_d = ST_FULL;
          end else if (deliver_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a delivery can move the buffer
          if (deliver_s) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    if (accept_s && new_s.illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and payload registers; reset drops any held entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.illegal;
  assign err_sticky      = err_q;

endmodule
